// File: rtl/bp_pkg.sv
// Shared widths, counter reset value and in-flight entry layout for the branch predictor.
// Purely declarative: no timing and no handshakes live here.
package bp_pkg;

    localparam int IDX_W = 6;
    localparam int GHR_W = 6;
    localparam int DEPTH = 4;

    localparam logic [1:0] CTR_RST = 2'b01;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             pred;
        logic [GHR_W-1:0] ghr;
    } bp_entry_t;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bp_ctrl_if.sv
// Fetch/execute-side bundle for the predictor: predict request/response and resolve path.
// All responses are combinational on the same cycle; pred_ready is the only backpressure.
interface bp_ctrl_if;

    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_ready;
    logic        pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        mispredict;
    logic        res_err;

    modport master (
        output pred_valid, pred_pc, res_valid, res_taken,
        input  pred_ready, pred_taken, mispredict, res_err
    );

    modport slave (
        input  pred_valid, pred_pc, res_valid, res_taken,
        output pred_ready, pred_taken, mispredict, res_err
    );

endinterface

// File: rtl/bp_inflight_q.sv
// In-order queue of outstanding predictions, DEPTH entries, head visible combinationally.
// Push/pop take effect at the next edge; a push while full is dropped, clear wins over both.
module bp_inflight_q #(
    parameter int DEPTH = bp_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              push,
    input  bp_pkg::bp_entry_t push_dat,
    input  logic              pop,
    input  logic              clear,
    output logic              full,
    output logic              empty,
    output bp_pkg::bp_entry_t head_dat
);
    import bp_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    bp_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[head];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_dat;
        end
    end

    // Pointers rely on DEPTH being a power of two so natural overflow is the wrap.
    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bp_ctrl.sv
// Gshare direction predictor with speculative/commit history and an in-flight resolve queue.
// Prediction is same-cycle combinational; pred_ready drops while DEPTH predictions are unresolved.
module bp_ctrl #(
    parameter int IDX_W = bp_pkg::IDX_W,
    parameter int GHR_W = bp_pkg::GHR_W,
    parameter int DEPTH = bp_pkg::DEPTH
) (
    input  logic      clk,
    input  logic      rstn,
    bp_ctrl_if.slave  bus
);
    import bp_pkg::*;

    logic [1:0]       pht [2**IDX_W];
    logic [GHR_W-1:0] ghr_spec;
    logic [GHR_W-1:0] ghr_commit;
    logic [IDX_W-1:0] pred_idx;
    bp_entry_t        push_dat;
    bp_entry_t        head_dat;
    logic             q_full;
    logic             q_empty;
    logic             accept;
    logic             do_pop;
    logic             flush;
    logic             ctl_unused;

    // GHR_W == IDX_W, so the history folds straight onto the index bits.
    assign pred_idx       = bus.pred_pc[IDX_W+1:2] ^ ghr_spec;
    assign bus.pred_taken = pht[pred_idx][1];
    assign bus.pred_ready = ~q_full;

    assign accept = bus.pred_valid & ~q_full;
    assign do_pop = rstn & bus.res_valid & ~q_empty;
    assign flush  = do_pop & (head_dat.pred != bus.res_taken);

    assign bus.mispredict = flush;
    assign bus.res_err    = rstn & bus.res_valid & q_empty;

    assign push_dat = '{idx: pred_idx, pred: bus.pred_taken, ghr: ghr_spec};

    assign ctl_unused = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0], head_dat.ghr,
                          ghr_commit[GHR_W-1]};

    bp_inflight_q #(
        .DEPTH (DEPTH)
    ) u_q (
        .clk      (clk),
        .rstn     (rstn),
        .push     (accept & ~flush),
        .push_dat (push_dat),
        .pop      (do_pop),
        .clear    (flush),
        .full     (q_full),
        .empty    (q_empty),
        .head_dat (head_dat)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 2**IDX_W; i++) begin
                pht[i] <= CTR_RST;
            end
            ghr_spec   <= '0;
            ghr_commit <= '0;
        end else begin
            if (do_pop) begin
                pht[head_dat.idx] <= ctr_next(pht[head_dat.idx], bus.res_taken);
                ghr_commit        <= {ghr_commit[GHR_W-2:0], bus.res_taken};
            end
            // A misprediction rebuilds speculative history from the now-updated commit history.
            if (flush) begin
                ghr_spec <= {ghr_commit[GHR_W-2:0], bus.res_taken};
            end else if (accept) begin
                ghr_spec <= {ghr_spec[GHR_W-2:0], bus.pred_taken};
            end
        end
    end

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed and randomized checks of bp_ctrl against a queue-based behavioural model.
module tb_bp_ctrl;
    import bp_pkg::*;

    localparam int NENT  = 2**IDX_W;
    localparam int GMASK = (1 << GHR_W) - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bp_ctrl_if bus();

    bp_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit pred;
    } ment_t;

    int    m_pht [NENT];
    int    m_gs;
    int    m_gc;
    ment_t mq[$];

    int    checks = 0;
    int    errors = 0;
    logic  obs_ready, obs_pt, obs_mis, obs_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] pc_for(input int target);
        return 32'h100 | 32'(((target ^ m_gs) & GMASK) << 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) m_pht[i] = 1;
        m_gs = 0;
        m_gc = 0;
        mq.delete();
    endtask

    task automatic chk_table(input string tag);
        for (int i = 0; i < NENT; i++) chk(tag, dut.pht[i], m_pht[i]);
    endtask

    task automatic chk_state();
        chk("count", dut.u_q.count, mq.size());
        chk("ghr_spec", dut.ghr_spec, m_gs);
        chk("ghr_commit", dut.ghr_commit, m_gc);
    endtask

    task automatic do_reset(input logic rv);
        rstn          = 1'b0;
        bus.pred_valid = 1'b1;
        bus.pred_pc    = $urandom;
        bus.res_valid  = rv;
        bus.res_taken  = 1'b1;
        #2;
        chk("rst_mispredict", bus.mispredict, 0);
        chk("rst_res_err", bus.res_err, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        chk_state();
        chk_table("rst_pht");
    endtask

    // One clock: drive, check combinational outputs mid-cycle, then check state after the edge.
    task automatic step(input logic pv, input logic [31:0] pc, input logic rv, input logic rt);
        bit    e_full, e_empty, e_pt, e_mis, e_err, popped;
        int    idx;
        ment_t ent;
        bus.pred_valid = pv;
        bus.pred_pc    = pc;
        bus.res_valid  = rv;
        bus.res_taken  = rt;
        #2;
        e_empty = (mq.size() == 0);
        e_full  = (mq.size() == DEPTH);
        idx     = ((pc >> 2) & (NENT - 1)) ^ m_gs;
        e_pt    = (m_pht[idx] >= 2);
        e_err   = rv && e_empty;
        e_mis   = rv && !e_empty && (mq[0].pred != rt);
        obs_ready = bus.pred_ready;
        obs_pt    = bus.pred_taken;
        obs_mis   = bus.mispredict;
        obs_err   = bus.res_err;
        chk("pred_ready", obs_ready, !e_full);
        chk("pred_taken", obs_pt, e_pt);
        chk("mispredict", obs_mis, e_mis);
        chk("res_err", obs_err, e_err);
        @(posedge clk);
        #1;
        popped = rv && !e_empty;
        if (popped) begin
            ent = mq.pop_front();
            if (rt) m_pht[ent.idx] = (m_pht[ent.idx] == 3) ? 3 : m_pht[ent.idx] + 1;
            else    m_pht[ent.idx] = (m_pht[ent.idx] == 0) ? 0 : m_pht[ent.idx] - 1;
            m_gc = ((m_gc << 1) | int'(rt)) & GMASK;
            chk("pht_update", dut.pht[ent.idx], m_pht[ent.idx]);
        end
        if (e_mis) begin
            mq.delete();
            m_gs = m_gc;
        end else if (pv && !e_full) begin
            mq.push_back('{idx, e_pt});
            m_gs = ((m_gs << 1) | int'(e_pt)) & GMASK;
        end
        chk_state();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic rt;
        do_reset(1'b0);

        // First prediction after reset.
        step(1'b1, 32'h100, 1'b0, 1'b0);
        chk("first_pred_taken", obs_pt, 0);
        chk("first_pred_ready", obs_ready, 1);
        chk("first_res_err", obs_err, 0);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Second taken resolve on index 0 saturates it.
        step(1'b1, pc_for(0), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("idx0_ctr_sat", dut.pht[0], 3);
        step(1'b1, pc_for(0), 1'b0, 1'b0);
        chk("idx0_pred_taken", obs_pt, 1);

        // Five taken resolves then one not-taken on index 0.
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step(1'b1, pc_for(0), 1'b0, 1'b0);
            step(1'b0, 32'h0, 1'b1, 1'b1);
            chk("taken_no_mispredict", obs_mis, 0);
        end
        step(1'b1, pc_for(0), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("not_taken_mispredict", obs_mis, 1);
        chk("idx0_ctr_weak", dut.pht[0], 2);
        step(1'b1, pc_for(0), 1'b0, 1'b0);
        chk("idx0_still_taken", obs_pt, 1);
        step(1'b0, 32'h0, 1'b1, 1'b1);

        // Fill the queue and check backpressure.
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b0, 1'b0);
        chk("full_not_ready", obs_ready, 0);
        chk("full_count_held", dut.u_q.count, 4);
        step(1'b0, 32'h0, 1'b1, mq[0].pred);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("ready_after_pop", obs_ready, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, mq[0].pred);

        // Mispredict with a same-cycle push flushes everything.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b1, $urandom, 1'b1, !mq[0].pred);
        chk("flush_mispredict", obs_mis, 1);
        chk("flush_count", dut.u_q.count, 0);
        chk("flush_ghr_spec", dut.ghr_spec, m_gc);

        // Resolve on an empty queue.
        step(1'b0, 32'h0, 1'b1, 1'($urandom_range(0, 1)));
        chk("empty_res_err", obs_err, 1);
        chk("empty_no_mispredict", obs_mis, 0);
        chk_table("empty_pht");

        // Reset mid-operation with a same-cycle resolve.
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        do_reset(1'b1);

        // Randomized traffic over a small index set.
        for (int n = 0; n < 600; n++) begin
            if (n % 200 == 199) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                rt = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].pred
                                                                   : 1'($urandom_range(0, 1));
                step(1'($urandom_range(0, 9) < 7),
                     ($urandom & 32'hFFFF_FF03) | (32'($urandom_range(0, 15)) << 2),
                     1'($urandom_range(0, 1)), rt);
            end
        end
        chk_table("final_pht");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
